// File: rtl/apple_iie_mmu_pkg.sv
// Shared constants and state types for the banked Apple IIe MMU.
// Soft-switch addresses are even bases; address bit 0 carries the switch value.
package apple_iie_mmu_pkg;

  localparam logic [15:0] SW_80STORE   = 16'hC000;
  localparam logic [15:0] SW_RAMRD     = 16'hC002;
  localparam logic [15:0] SW_RAMWRT    = 16'hC004;
  localparam logic [15:0] SW_INTCXROM  = 16'hC006;
  localparam logic [15:0] SW_ALTZP     = 16'hC008;
  localparam logic [15:0] SW_SLOTC3ROM = 16'hC00A;
  localparam logic [15:0] SW_PAGE2     = 16'hC054;
  localparam logic [15:0] SW_HIRES     = 16'hC056;
  localparam logic [15:0] STATUS_BASE  = 16'hC010;
  localparam logic [15:0] LC_BASE      = 16'hC080;

  localparam logic [15:0] ZP_END  = 16'h01FF;
  localparam logic [15:0] TEXT_LO = 16'h0400;
  localparam logic [15:0] TEXT_HI = 16'h07FF;
  localparam logic [15:0] HGR_LO  = 16'h2000;
  localparam logic [15:0] HGR_HI  = 16'h3FFF;
  localparam logic [15:0] RAM_HI  = 16'hBFFF;
  localparam logic [15:0] CX_LO   = 16'hC100;
  localparam logic [15:0] C3_LO   = 16'hC300;
  localparam logic [15:0] C3_HI   = 16'hC3FF;
  localparam logic [15:0] C8_LO   = 16'hC800;
  localparam logic [15:0] C8_CLR  = 16'hCFFF;
  localparam logic [15:0] LC_LO   = 16'hD000;

  typedef struct packed {
    logic reads_ram;
    logic write_en;
    logic bank2;
    logic prewrite;
  } lc_state_t;

  localparam lc_state_t LC_RESET = '{reads_ram: 1'b0, write_en: 1'b1,
                                     bank2: 1'b1, prewrite: 1'b0};

  typedef struct packed {
    logic store80;
    logic ramrd;
    logic ramwrt;
    logic altzp;
    logic page2;
    logic hires;
    logic intcxrom;
    logic slotc3rom;
    logic intc8rom;
  } sw_state_t;

endpackage

// File: rtl/apple_iie_language_card.sv
// Language-card bank/read/write-enable state, including the two-odd-read
// pre-write arming sequence. State is exposed directly as lc_state.
module apple_iie_language_card
  import apple_iie_mmu_pkg::*;
#(
  parameter bit ENABLE_PREWRITE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] a,
  input  logic        rw_n,
  output lc_state_t   lc_state
);

  lc_state_t lc_q, lc_d;
  logic      hit;
  logic      unused_a2;

  assign unused_a2 = a[2];

  always_comb begin
    hit  = (a[15:4] == LC_BASE[15:4]);
    lc_d = lc_q;
    if (hit) begin
      lc_d.bank2     = ~a[3];
      lc_d.reads_ram = (a[1] == a[0]);
      if (!a[0]) begin
        lc_d.write_en = 1'b0;
        lc_d.prewrite = 1'b0;
      end else if (!ENABLE_PREWRITE) begin
        lc_d.write_en = 1'b1;
        lc_d.prewrite = 1'b0;
      end else if (rw_n) begin
        // Second consecutive odd read (no odd write between) enables writes.
        if (lc_q.prewrite) lc_d.write_en = 1'b1;
        lc_d.prewrite = 1'b1;
      end else begin
        lc_d.prewrite = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) lc_q <= LC_RESET;
    else       lc_q <= lc_d;
  end

  assign lc_state = lc_q;

endmodule

// File: rtl/apple_iie_banked_mmu.sv
// Apple IIe MMU with banked aux memory: soft switches, bank register,
// INTC8ROM tracking, and a 1-cycle-latency decode of the registered bus cycle.
module apple_iie_banked_mmu
  import apple_iie_mmu_pkg::*;
#(
  parameter int          NUM_AUX_BANKS   = 1,
  parameter logic [15:0] BANK_REG_ADDR   = 16'hC073,
  parameter int          ENABLE_PREWRITE = 1,
  localparam int         BANK_W = (NUM_AUX_BANKS > 1) ? $clog2(NUM_AUX_BANKS) : 1
) (
  input  logic              clk_phi_0,
  input  logic              reset,
  input  logic [15:0]       a,
  input  logic              rw_n,
  input  logic [7:0]        d_in,
  output logic              ramen_n,
  output logic              en80_n,
  output logic [BANK_W-1:0] aux_bank,
  output logic              romen_n,
  output logic              lc_bank2,
  output logic              cxxx,
  output logic              md7,
  output logic              md7_oe
);

  sw_state_t         sw_q, sw_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [15:0]       req_a_q, req_a_d;
  logic              req_rw_q, req_rw_d;
  lc_state_t         lc;
  logic              ram_sel, to_aux, rom_sel, rd;
  logic              unused_d_in;

  assign unused_d_in = ^d_in;

  apple_iie_language_card #(.ENABLE_PREWRITE(ENABLE_PREWRITE != 0)) u_lc (
    .clk      (clk_phi_0),
    .reset    (reset),
    .a        (a),
    .rw_n     (rw_n),
    .lc_state (lc)
  );

  always_comb begin
    req_a_d  = a;
    req_rw_d = rw_n;
    sw_d     = sw_q;
    bank_d   = bank_q;
    if (!rw_n) begin
      if (a[15:1] == SW_80STORE[15:1])   sw_d.store80   = a[0];
      if (a[15:1] == SW_RAMRD[15:1])     sw_d.ramrd     = a[0];
      if (a[15:1] == SW_RAMWRT[15:1])    sw_d.ramwrt    = a[0];
      if (a[15:1] == SW_ALTZP[15:1])     sw_d.altzp     = a[0];
      if (a[15:1] == SW_INTCXROM[15:1])  sw_d.intcxrom  = a[0];
      if (a[15:1] == SW_SLOTC3ROM[15:1]) sw_d.slotc3rom = a[0];
      if (a == BANK_REG_ADDR) bank_d = (NUM_AUX_BANKS > 1) ? d_in[BANK_W-1:0] : '0;
    end
    if (a[15:1] == SW_PAGE2[15:1]) sw_d.page2 = a[0];
    if (a[15:1] == SW_HIRES[15:1]) sw_d.hires = a[0];
    // Clear is applied last so it wins over a same-cycle set.
    if (a >= C3_LO && a <= C3_HI && !sw_q.slotc3rom) sw_d.intc8rom = 1'b1;
    if (a == C8_CLR) sw_d.intc8rom = 1'b0;
  end

  always_ff @(posedge clk_phi_0) begin
    if (reset) begin
      sw_q     <= '0;
      bank_q   <= '0;
      req_a_q  <= '0;
      req_rw_q <= 1'b1;
    end else begin
      sw_q     <= sw_d;
      bank_q   <= bank_d;
      req_a_q  <= req_a_d;
      req_rw_q <= req_rw_d;
    end
  end

  always_comb begin
    rd      = req_rw_q;
    ram_sel = 1'b0;
    to_aux  = 1'b0;
    rom_sel = 1'b0;
    if (req_a_q <= RAM_HI) begin
      ram_sel = 1'b1;
      if (req_a_q <= ZP_END) begin
        to_aux = sw_q.altzp;
      end else begin
        to_aux = rd ? sw_q.ramrd : sw_q.ramwrt;
        if (sw_q.store80 && req_a_q >= TEXT_LO && req_a_q <= TEXT_HI)
          to_aux = sw_q.page2;
        if (sw_q.store80 && sw_q.hires && req_a_q >= HGR_LO && req_a_q <= HGR_HI)
          to_aux = sw_q.page2;
      end
    end else if (req_a_q >= LC_LO) begin
      if ((rd && lc.reads_ram) || (!rd && lc.write_en)) begin
        ram_sel = 1'b1;
        to_aux  = sw_q.altzp;
      end else begin
        rom_sel = rd;
      end
    end else if (rd && req_a_q >= CX_LO) begin
      rom_sel = sw_q.intcxrom
             || (req_a_q >= C3_LO && req_a_q <= C3_HI && !sw_q.slotc3rom)
             || (req_a_q >= C8_LO && sw_q.intc8rom);
    end
  end

  always_comb begin
    md7_oe = rd && (req_a_q[15:4] == STATUS_BASE[15:4]) && (req_a_q[3:0] != 4'h0);
    md7    = 1'b0;
    if (md7_oe) begin
      case (req_a_q[3:0])
        4'h1:    md7 = lc.bank2;
        4'h2:    md7 = lc.reads_ram;
        4'h3:    md7 = sw_q.ramrd;
        4'h4:    md7 = sw_q.ramwrt;
        4'h5:    md7 = sw_q.intcxrom;
        4'h6:    md7 = sw_q.altzp;
        4'h7:    md7 = sw_q.slotc3rom;
        4'h8:    md7 = sw_q.store80;
        4'hC:    md7 = sw_q.page2;
        4'hD:    md7 = sw_q.hires;
        default: md7 = 1'b0;
      endcase
    end
  end

  assign ramen_n  = !(ram_sel && !to_aux);
  assign en80_n   = !(ram_sel && to_aux);
  assign romen_n  = !rom_sel;
  assign aux_bank = bank_q;
  assign lc_bank2 = lc.bank2;
  assign cxxx     = (req_a_q[15:12] == 4'hC);

endmodule

// File: tb/tb_apple_iie_banked_mmu.sv
// Table-driven bench for apple_iie_banked_mmu (16 aux banks): each vector's
// expected outputs are queued when driven and compared one cycle later.
module tb_apple_iie_banked_mmu;

  logic        clk_phi_0 = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] a = 16'h0000;
  logic        rw_n = 1'b1;
  logic [7:0]  d_in = 8'h00;
  logic        ramen_n, en80_n, romen_n, lc_bank2, cxxx, md7, md7_oe;
  logic [3:0]  aux_bank;

  apple_iie_banked_mmu #(.NUM_AUX_BANKS(16)) dut (
    .clk_phi_0 (clk_phi_0),
    .reset     (reset),
    .a         (a),
    .rw_n      (rw_n),
    .d_in      (d_in),
    .ramen_n   (ramen_n),
    .en80_n    (en80_n),
    .aux_bank  (aux_bank),
    .romen_n   (romen_n),
    .lc_bank2  (lc_bank2),
    .cxxx      (cxxx),
    .md7       (md7),
    .md7_oe    (md7_oe)
  );

  always #5 clk_phi_0 = ~clk_phi_0;

  typedef struct {
    logic        rst;
    logic [15:0] a;
    logic        rw_n;
    logic [7:0]  d;
    logic [10:0] exp;
  } vec_t;

  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  vec_t        vecs[$];
  logic [10:0] exp_q[$];
  int          id_q[$];
  int          n_applied = 0;
  int          n_fail = 0;

  // Packing: {ramen_n, en80_n, romen_n, lc_bank2, cxxx, md7, md7_oe, aux_bank}
  function automatic logic [10:0] mk(input logic r, input logic e, input logic o,
                                     input logic b, input logic x, input logic m,
                                     input logic v, input logic [3:0] ab);
    return {r, e, o, b, x, m, v, ab};
  endfunction

  task automatic add(input logic rst, input logic [15:0] aa, input logic rw,
                     input logic [7:0] dd, input logic [10:0] e);
    vec_t v;
    v.rst = rst; v.a = aa; v.rw_n = rw; v.d = dd; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check();
    logic [10:0] got, e;
    int          id;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      id  = id_q.pop_front();
      got = {ramen_n, en80_n, romen_n, lc_bank2, cxxx, md7, md7_oe, aux_bank};
      n_applied++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL vec%0d outputs {ramen_n,en80_n,romen_n,bank2,cxxx,md7,md7_oe,aux}: got=%b expected=%b",
                 id, got, e);
      end
    end
  endtask

  task automatic drive(input logic rst, input logic [15:0] aa, input logic rw,
                       input logic [7:0] dd, input logic [10:0] e, input int id);
    @(negedge clk_phi_0);
    check();
    reset = rst; a = aa; rw_n = rw; d_in = dd;
    exp_q.push_back(e);
    id_q.push_back(id);
  endtask

  initial begin
    logic [15:0] ra;
    // Reset and language-card pre-write sequences
    add(1, 16'h1234, RD, 8'h00, mk(0,1,1,1,0,0,0,4'h0));
    add(0, 16'hC080, RD, 8'h00, mk(1,1,1,1,1,0,0,4'h0));
    add(0, 16'hC081, RD, 8'h00, mk(1,1,1,1,1,0,0,4'h0));
    add(0, 16'hD000, WR, 8'h00, mk(1,1,1,1,0,0,0,4'h0));
    add(0, 16'hC081, RD, 8'h00, mk(1,1,1,1,1,0,0,4'h0));
    add(0, 16'hD000, WR, 8'h00, mk(0,1,1,1,0,0,0,4'h0));
    add(0, 16'hD000, RD, 8'h00, mk(1,1,0,1,0,0,0,4'h0));
    add(0, 16'hC011, RD, 8'h00, mk(1,1,1,1,1,1,1,4'h0));
    add(0, 16'hC080, RD, 8'h00, mk(1,1,1,1,1,0,0,4'h0));
    add(0, 16'hC081, RD, 8'h00, mk(1,1,1,1,1,0,0,4'h0));
    add(0, 16'hC081, WR, 8'h00, mk(1,1,1,1,1,0,0,4'h0));
    add(0, 16'hC081, RD, 8'h00, mk(1,1,1,1,1,0,0,4'h0));
    add(0, 16'hD000, WR, 8'h00, mk(1,1,1,1,0,0,0,4'h0));
    add(0, 16'hC012, RD, 8'h00, mk(1,1,1,1,1,0,1,4'h0));
    add(0, 16'hC08B, RD, 8'h00, mk(1,1,1,0,1,0,0,4'h0));
    add(0, 16'hD000, RD, 8'h00, mk(0,1,1,0,0,0,0,4'h0));
    // Aux bank register and ramwrt
    add(0, 16'hC005, WR, 8'h00, mk(1,1,1,0,1,0,0,4'h0));
    add(0, 16'hC073, WR, 8'h2B, mk(1,1,1,0,1,0,0,4'hB));
    add(0, 16'h4000, WR, 8'h00, mk(1,0,1,0,0,0,0,4'hB));
    add(0, 16'h4000, RD, 8'h00, mk(0,1,1,0,0,0,0,4'hB));
    add(0, 16'hC073, WR, 8'hF5, mk(1,1,1,0,1,0,0,4'h5));
    // 80store / page2 / hires overrides
    add(0, 16'hC001, WR, 8'h00, mk(1,1,1,0,1,0,0,4'h5));
    add(0, 16'hC055, WR, 8'h00, mk(1,1,1,0,1,0,0,4'h5));
    add(0, 16'h0400, WR, 8'h00, mk(1,0,1,0,0,0,0,4'h5));
    add(0, 16'h0400, RD, 8'h00, mk(1,0,1,0,0,0,0,4'h5));
    add(0, 16'hC054, RD, 8'h00, mk(1,1,1,0,1,0,0,4'h5));
    add(0, 16'h0400, WR, 8'h00, mk(0,1,1,0,0,0,0,4'h5));
    add(0, 16'h2000, WR, 8'h00, mk(1,0,1,0,0,0,0,4'h5));
    add(0, 16'hC057, WR, 8'h00, mk(1,1,1,0,1,0,0,4'h5));
    add(0, 16'h2000, WR, 8'h00, mk(0,1,1,0,0,0,0,4'h5));
    add(0, 16'hC004, WR, 8'h00, mk(1,1,1,0,1,0,0,4'h5));
    // Internal ROM switches
    add(0, 16'hC300, RD, 8'h00, mk(1,1,0,0,1,0,0,4'h5));
    add(0, 16'hC800, RD, 8'h00, mk(1,1,0,0,1,0,0,4'h5));
    add(0, 16'hCFFF, RD, 8'h00, mk(1,1,1,0,1,0,0,4'h5));
    add(0, 16'hC800, RD, 8'h00, mk(1,1,1,0,1,0,0,4'h5));
    add(0, 16'hC00B, WR, 8'h00, mk(1,1,1,0,1,0,0,4'h5));
    add(0, 16'hC300, RD, 8'h00, mk(1,1,1,0,1,0,0,4'h5));
    add(0, 16'hC017, RD, 8'h00, mk(1,1,1,0,1,1,1,4'h5));
    add(0, 16'hC007, WR, 8'h00, mk(1,1,1,0,1,0,0,4'h5));
    add(0, 16'hC100, RD, 8'h00, mk(1,1,0,0,1,0,0,4'h5));
    add(0, 16'hC100, WR, 8'h00, mk(1,1,1,0,1,0,0,4'h5));
    add(0, 16'hC015, RD, 8'h00, mk(1,1,1,0,1,1,1,4'h5));
    add(0, 16'hC006, WR, 8'h00, mk(1,1,1,0,1,0,0,4'h5));
    // altzp, status reads, reset
    add(0, 16'hC009, WR, 8'h00, mk(1,1,1,0,1,0,0,4'h5));
    add(0, 16'hC016, RD, 8'h00, mk(1,1,1,0,1,1,1,4'h5));
    add(0, 16'h0100, RD, 8'h00, mk(1,0,1,0,0,0,0,4'h5));
    add(0, 16'hE000, RD, 8'h00, mk(1,0,1,0,0,0,0,4'h5));
    add(0, 16'hC019, RD, 8'h00, mk(1,1,1,0,1,0,1,4'h5));
    add(1, 16'hC081, RD, 8'h00, mk(0,1,1,1,0,0,0,4'h0));
    add(0, 16'h0100, RD, 8'h00, mk(0,1,1,1,0,0,0,4'h0));
    // Reset in the middle of a pre-write sequence
    add(0, 16'hC080, RD, 8'h00, mk(1,1,1,1,1,0,0,4'h0));
    add(0, 16'hC081, RD, 8'h00, mk(1,1,1,1,1,0,0,4'h0));
    add(1, 16'hC081, RD, 8'h00, mk(0,1,1,1,0,0,0,4'h0));
    add(0, 16'hD000, WR, 8'h00, mk(0,1,1,1,0,0,0,4'h0));
    add(0, 16'hD000, RD, 8'h00, mk(1,1,0,1,0,0,0,4'h0));

    for (int i = 0; i < vecs.size(); i++)
      drive(vecs[i].rst, vecs[i].a, vecs[i].rw_n, vecs[i].d, vecs[i].exp, i);

    // Random main-memory traffic after reset: all switches off selects main RAM.
    drive(1, 16'h0000, RD, 8'h00, mk(0,1,1,1,0,0,0,4'h0), 1000);
    for (int i = 0; i < 16; i++) begin
      ra = 16'($urandom_range(16'h0000, 16'hBFFF));
      drive(0, ra, logic'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            mk(0,1,1,1,0,0,0,4'h0), 1001 + i);
    end
    drive(0, 16'hC018, RD, 8'h00, mk(1,1,1,1,1,0,1,4'h0), 1100);

    @(negedge clk_phi_0);
    check();
    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
    $finish;
  end

endmodule

// File: doc/apple_iie_banked_mmu.md
Name: apple_iie_banked_mmu

Overview:
Parametrised successor to the IIe MMU. It decodes CPU bus cycles into main, auxiliary and ROM enables, and extends aux memory to NUM_AUX_BANKS banks through a bank register. It implements the real language-card two-read pre-write sequence and the INTCXROM / SLOTC3ROM / INTC8ROM internal-ROM switches. It sits between the CPU bus and the RAM/ROM array, with one CPU cycle per clock.

Parameters:
NUM_AUX_BANKS, 1, number of 64K aux banks; power of 2 from 1 to 256. BANK_W = max(1, clog2(NUM_AUX_BANKS)) is a derived localparam.
BANK_REG_ADDR, 16'hC073, write address of the aux bank register.
ENABLE_PREWRITE, 1, 1 gives genuine two-read LC write enable; 0 gives a single-access write enable.

Ports:
clk_phi_0  in  1  system clock; a, rw_n and d_in are sampled on each rising edge, one CPU cycle per edge.
reset  in  1  synchronous, active-high.
a  in  16  CPU address.
rw_n  in  1  1 = read.
d_in  in  8  CPU write data; used only for the bank register.
ramen_n  out  1  main RAM enable, active low.
en80_n  out  1  aux RAM enable, active low.
aux_bank  out  BANK_W  aux bank currently addressed.
romen_n  out  1  internal ROM enable, active low.
lc_bank2  out  1  language-card bank 2 selected.
cxxx  out  1  latched address is in $Cxxx.
md7  out  1  status bit for $C01x reads.
md7_oe  out  1  md7 drive enable.

Behaviour:
- Each edge: register the address into req_a and rw_n into req_rw, then update state per the rules below. Outputs decode combinationally from req_a, req_rw and state, so there is 1-cycle latency.
- Reset values:
  - All soft switches 0: 80store, ramrd, ramwrt, altzp, page2, hires, intcxrom, slotc3rom, intc8rom.
  - LC: reads_ram=0, write_en=1, bank2=1, prewrite=0.
  - aux_bank=0, md7=0, req_a=0, req_rw=1.
  - Resulting outputs: ramen_n=0, en80_n=1, romen_n=1, md7_oe=0.
- Soft-switch writes, with rw_n=0 and a[0] giving the value:
  - $C000/1 → 80store; $C002/3 → ramrd; $C004/5 → ramwrt; $C008/9 → altzp.
  - $C006/7 → intcxrom; $C00A/B → slotc3rom.
  - $C054/5 → page2, $C056/7 → hires. These respond on reads and writes.
- Bank register: a write to BANK_REG_ADDR sets aux_bank <= d_in[BANK_W-1:0], so upper bits wrap modulo NUM_AUX_BANKS.
- Language card, on any access to $C080-$C08F:
  - bank2 <= ~a[3].
  - reads_ram <= (a[1]==a[0]).
  - If a[0]=0: write_en<=0 and prewrite<=0.
  - If a[0]=1 and the access is a read: when prewrite=1, write_en<=1; prewrite<=1.
  - If a[0]=1 and the access is a write: prewrite<=0 and write_en is unchanged.
  - With ENABLE_PREWRITE=0, any odd access sets write_en=1.
  - Any non-$C08x cycle leaves prewrite unchanged.
- INTC8ROM:
  - Set on any access to $C300-$C3FF while slotc3rom=0.
  - Cleared on any access to $CFFF.
  - If both apply in the same cycle, clear wins; this cannot occur in practice.
- Decode, where aux_sel means en80_n=0 and main_sel means ramen_n=0:
  - $0000-$01FF uses altzp.
  - $0200-$BFFF uses ramrd on reads and ramwrt on writes.
  - $0400-$07FF is overridden by page2 when 80store=1.
  - $2000-$3FFF is overridden by page2 when 80store=1 and hires=1.
  - $D000-$FFFF: RAM when (read and reads_ram) or (write and write_en), routed aux if altzp else main. A ROM read there gives romen_n=0. A write with write_en=0 selects nothing.
  - $C100-$CFFF reads: romen_n=0 when intcxrom=1, when in $C300-$C3FF with slotc3rom=0, or when in $C800-$CFFF with intc8rom=1.
  - $C000-$CFFF never asserts ramen_n or en80_n.
  - ramen_n and en80_n are never low simultaneously.
- aux_bank is driven at all times; downstream uses it only when en80_n=0.
- Status reads of $C011-$C01F drive md7_oe=1 in the cycle after the read, with md7 as listed:
  - $C011 bank2, $C012 reads_ram, $C013 ramrd, $C014 ramwrt.
  - $C015 intcxrom, $C016 altzp, $C017 slotc3rom, $C018 80store.
  - $C01C page2, $C01D hires; other addresses give 0.
  - md7_oe=0 otherwise.
- Reset asserted mid-sequence, for example after one pre-write read, returns all state to the reset values; the next odd read then only sets prewrite.

Decomposition:
- Package apple_iie_mmu_pkg holds the soft-switch address constants, the $C08x base, the region boundary constants and the LC state struct {reads_ram, write_en, bank2, prewrite}.
- One sub-module, apple_iie_language_card, holds the LC state machine. The top level holds the switches, the bank register, INTC8ROM and the decode.

Test Plan:
- Read $C081 twice, then write $D000 → after the first read write_en=0 and a $D000 write gives ramen_n=1 and en80_n=1; after the second, a $D000 write gives ramen_n=0 and a $D000 read gives romen_n=0.
- Read $C081, write $C081, read $C081 → write_en stays 0, because the intervening write clears prewrite.
- NUM_AUX_BANKS=16: write $C005, write $C073 with d_in=8'h2B, write $4000 → en80_n=0, ramen_n=1, aux_bank=4'hB.
- Write $C001 and $C055, then access $0400 → en80_n=0 regardless of ramwrt; write $C054, then access $0400 → ramen_n=0.
- With slotc3rom=0: read $C300 then $C800 → romen_n=0 on both; read $CFFF, then $C800 → romen_n=1.
- Write $C009, read $C016 → next cycle md7_oe=1, md7=1; assert reset → next cycle en80_n=1, md7_oe=0, lc_bank2=1.
